// File: rtl/exec_controller.sv
// exec_controller: run/single-step execution control FSM with stop detection
// and a saturating executed-instruction counter.
module exec_controller #(
  parameter int MSB      = 11,
  parameter int OPC_W    = 5,
  parameter int CNT_W    = 16,
  parameter int HALT_OPC = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_mode,
  input  logic             i_step,
  input  logic             i_clear,
  input  logic [OPC_W-1:0] i_opcode,
  input  logic [MSB-1:0]   i_pc,
  output logic             o_pc_en,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_done,
  output logic [CNT_W-1:0] o_icount
);
  typedef enum logic [2:0] {IDLE, RUN, STEP_WAIT, STEP_EXEC, HALT} state_t;
  state_t state, state_n;
  logic stop;
  // an all-ones PC stops execution so the PC never wraps to zero
  assign stop = (i_opcode == OPC_W'(HALT_OPC)) || (&i_pc);
  always_comb begin
    state_n = state;
    o_pc_en = 1'b0;
    if (i_rst || i_clear) state_n = IDLE;
    else case (state)
      IDLE:      if (i_start) state_n = i_mode ? STEP_WAIT : RUN;
      RUN:       begin
        o_pc_en = !stop;
        state_n = stop ? HALT : RUN;
      end
      STEP_WAIT: if (i_step) state_n = stop ? HALT : STEP_EXEC;
      STEP_EXEC: begin
        o_pc_en = 1'b1;
        state_n = STEP_WAIT;
      end
      HALT:      state_n = HALT;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    state  <= state_n;
    o_done <= (state_n == HALT) && (state != HALT);
    if (i_rst || i_clear) o_icount <= '0;
    else if (o_pc_en && !(&o_icount)) o_icount <= o_icount + 1'b1;
  end
  assign o_busy   = (state == RUN) || (state == STEP_WAIT) || (state == STEP_EXEC);
  assign o_halted = (state == HALT);
endmodule

// File: tb/tb_exec_controller.sv
// tb_exec_controller: directed and random stimulus checked against a flag-based
// behavioural model; a second instance with a 3-bit counter covers saturation.
module tb_exec_controller;
  logic clk = 1'b0;
  logic i_rst, i_start, i_mode, i_step, i_clear;
  logic [4:0] i_opcode;
  logic [10:0] i_pc;
  logic pc_en, busy, halted, done;
  logic [15:0] icount;
  logic pc_en3, busy3, halted3, done3;
  logic [2:0] icount3;
  int total = 0, bad = 0;
  bit m_busy, m_step, m_exec, m_halt, m_done;
  int m_cnt, m_cnt3;

  always #5 clk = ~clk;

  exec_controller dut (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode), .i_step(i_step),
    .i_clear(i_clear), .i_opcode(i_opcode), .i_pc(i_pc), .o_pc_en(pc_en), .o_busy(busy),
    .o_halted(halted), .o_done(done), .o_icount(icount)
  );

  exec_controller #(.CNT_W(3)) dut3 (
    .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode), .i_step(i_step),
    .i_clear(i_clear), .i_opcode(i_opcode), .i_pc(i_pc), .o_pc_en(pc_en3), .o_busy(busy3),
    .o_halted(halted3), .o_done(done3), .o_icount(icount3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input bit pen);
    chk("pc_en", pc_en, pen);
    chk("busy", busy, m_busy);
    chk("halted", halted, m_halt);
    chk("done", done, m_done);
    chk("icount", icount, m_cnt);
    chk("pc_en3", pc_en3, pen);
    chk("busy3", busy3, m_busy);
    chk("halted3", halted3, m_halt);
    chk("done3", done3, m_done);
    chk("icount3", icount3, m_cnt3);
  endtask

  // one clock cycle: drive, check mid-cycle against the model, advance the model at the edge
  task automatic tick(input bit rst, input bit start, input bit mode, input bit step,
                      input bit clear, input logic [4:0] opc, input logic [10:0] pc);
    bit stop, pen;
    i_rst = rst; i_start = start; i_mode = mode; i_step = step; i_clear = clear;
    i_opcode = opc; i_pc = pc;
    #3;
    stop = (opc == 5'd0) || (pc == 11'h7FF);
    pen = !rst && !clear && ((m_busy && !m_step && !stop) || m_exec);
    check_outputs(pen);
    @(posedge clk);
    #1;
    if (rst || clear) begin
      {m_busy, m_step, m_exec, m_halt, m_done} = '0;
      m_cnt = 0;
      m_cnt3 = 0;
    end else begin
      m_done = 1'b0;
      if (pen) begin
        m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
        m_cnt3 = (m_cnt3 < 7) ? m_cnt3 + 1 : m_cnt3;
      end
      if (!m_busy && !m_halt) begin
        if (start) begin m_busy = 1'b1; m_step = mode; end
      end else if (m_busy && !m_step) begin
        if (stop) begin m_busy = 1'b0; m_halt = 1'b1; m_done = 1'b1; end
      end else if (m_exec) m_exec = 1'b0;
      else if (m_busy && step) begin
        if (stop) begin m_busy = 1'b0; m_step = 1'b0; m_halt = 1'b1; m_done = 1'b1; end
        else m_exec = 1'b1;
      end
    end
  endtask

  task automatic idle_tick(input logic [4:0] opc, input logic [10:0] pc);
    tick(0, 0, 0, 0, 0, opc, pc);
  endtask

  initial begin
    {i_rst, i_start, i_mode, i_step, i_clear} = 5'b10000;
    i_opcode = 5'd1;
    i_pc = 11'd0;
    @(posedge clk);
    #1;
    {m_busy, m_step, m_exec, m_halt, m_done} = '0;
    m_cnt = 0;
    m_cnt3 = 0;
    tick(1, 0, 0, 0, 0, 5'd1, 11'd0);
    chk("reset_busy", busy, 0);
    chk("reset_icount", icount, 0);
    // continuous run: five instructions then a halt opcode
    tick(0, 1, 0, 0, 0, 5'd1, 11'd0);
    for (int i = 0; i < 5; i++) idle_tick(5'd3, 11'(i));
    idle_tick(5'd0, 11'd5);
    chk("run_done", done, 1);
    chk("run_halted", halted, 1);
    chk("run_icount", icount, 5);
    idle_tick(5'd0, 11'd5);
    chk("run_done_once", done, 0);
    tick(0, 0, 0, 0, 1, 5'd1, 11'd0);
    // single step: three spaced step pulses
    tick(0, 1, 1, 0, 0, 5'd1, 11'd0);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 1, 0, 5'd2, 11'(i));
      for (int j = 0; j < 3; j++) idle_tick(5'd2, 11'(i + 1));
    end
    chk("step_icount", icount, 3);
    chk("step_busy", busy, 1);
    tick(0, 0, 0, 0, 1, 5'd1, 11'd0);
    // PC boundary: all-ones PC stops execution
    tick(0, 1, 0, 0, 0, 5'd1, 11'h7FD);
    idle_tick(5'd1, 11'h7FE);
    idle_tick(5'd1, 11'h7FF);
    chk("pc_bound_halted", halted, 1);
    chk("pc_bound_icount", icount, 1);
    tick(0, 0, 0, 0, 1, 5'd1, 11'd0);
    // clear priority over start, and clear mid-run
    tick(0, 1, 0, 0, 1, 5'd1, 11'd0);
    chk("clr_start_busy", busy, 0);
    tick(0, 1, 0, 0, 0, 5'd1, 11'd0);
    idle_tick(5'd1, 11'd1);
    idle_tick(5'd1, 11'd2);
    tick(0, 0, 0, 0, 1, 5'd1, 11'd3);
    chk("clr_run_icount", icount, 0);
    chk("clr_run_busy", busy, 0);
    // saturation on the 3-bit counter instance
    tick(0, 1, 0, 0, 0, 5'd1, 11'd0);
    for (int i = 0; i < 10; i++) idle_tick(5'd4, 11'(i));
    chk("sat_icount3", icount3, 7);
    chk("sat_icount", icount, 10);
    tick(0, 0, 0, 0, 1, 5'd1, 11'd0);
    // reset while a step executes; later steps ignored until a start
    tick(0, 1, 1, 0, 0, 5'd1, 11'd0);
    tick(0, 0, 0, 1, 0, 5'd1, 11'd0);
    tick(1, 0, 0, 1, 0, 5'd1, 11'd1);
    tick(0, 0, 0, 1, 0, 5'd1, 11'd1);
    tick(0, 0, 0, 1, 0, 5'd1, 11'd1);
    chk("rst_step_busy", busy, 0);
    chk("rst_step_icount", icount, 0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, 1'($urandom),
           $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0,
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
           ($urandom_range(0, 15) == 0) ? 11'h7FF : 11'($urandom_range(0, 2046)));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
